vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Upstream timing stage for the on-screen clock overlay.
- Derives a pixel-rate tick from the system clock and runs the horizontal/vertical pixel counters.
- Produces the h_sinc/v_sinc pulses, an active-video flag and pixel coordinates, all mutually aligned.
- The digit-drawing stage consumes h_sinc, v_sinc, pix_x and pix_y; coordinates are 11-bit to match its counters.

Parameters:
- CLK_DIV, 2: system clocks per pixel (50 MHz clk -> 25 MHz pixel rate); legal range >= 1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, pixels.
- H_SYNC, 96: horizontal sync width, pixels.
- H_BP, 48: horizontal back porch, pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, lines.
- V_SYNC, 2: vertical sync width, lines.
- V_BP, 33: vertical back porch, lines.
- SYNC_ACT, 0: level of h_sinc/v_sinc while the pulse is asserted.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  synchronous run enable; low freezes divider and counters.
- pix_tick  out  1  one-clk pulse each pixel period.
- h_sinc  out  1  horizontal sync.
- v_sinc  out  1  vertical sync.
- video_on  out  1  high while (pix_x, pix_y) is in the visible area.
- pix_x  out  11  current horizontal count, 0..H_TOTAL-1.
- pix_y  out  11  current vertical count, 0..V_TOTAL-1.
- frame_start  out  1  one-clk pulse coinciding with the tick that enters (0,0).

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset state (asynchronous, while rst_n=0):
  - divider = 0;
  - internal h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1;
  - outputs: pix_tick=0, frame_start=0, video_on=0, h_sinc=v_sinc=!SYNC_ACT, pix_x=H_TOTAL-1, pix_y=V_TOTAL-1.
- Divider:
  - Counts 0..CLK_DIV-1 while en=1.
  - pix_tick=1 for the single clk in which divider==CLK_DIV-1. The first tick after reset release is on the CLK_DIV-th enabled edge.
  - With CLK_DIV=1, pix_tick is constant 1 while en=1.
- Counters, advanced only on a pix_tick clk:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - When h_cnt and v_cnt are both at their maxima, both wrap to 0 on the same tick.
- All outputs are registered and updated on the same edge as the counters (decoded from next-state values), so there is zero skew between them:
  - pix_x = h_cnt, pix_y = v_cnt.
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - h_sinc = SYNC_ACT iff h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
  - v_sinc = SYNC_ACT iff v_cnt is in [490, 491]. v_sinc changes only together with h_cnt wrapping to 0.
  - frame_start = 1 for exactly one clk: the clk in which the counters become (0,0).
- Sync outputs in real time: each h_sinc pulse is H_SYNC*CLK_DIV clks long; each v_sinc pulse is V_SYNC*H_TOTAL*CLK_DIV clks long.
- en=0:
  - Divider, counters and all level outputs hold.
  - pix_tick and frame_start are forced 0.
  - Resuming continues from the held divider phase; no tick is lost or duplicated.
- Reset mid-frame: immediate return to the reset state. The first frame after release begins with frame_start at (0,0).
- Width rule: counters are 11 bits; compare against the derived totals at full width, never truncated.

Decomposition:
- Package vga_timing_pkg:
  - localparams for the 640x480@60 defaults;
  - derived H_TOTAL, V_TOTAL, H_SYNC_START/END, V_SYNC_START/END;
  - COORD_W = 11.
- One sub-module, pix_tick_gen:
  - ports clk, rst_n, en, tick; parameter CLK_DIV;
  - owns the divider.
- The counter and decode logic stays in vga_sync_gen.

Test Plan:
1. Release rst_n with en=1 and CLK_DIV=2 -> first pix_tick on clk edge 2, together with frame_start=1, pix_x=0, pix_y=0, video_on=1; pix_tick then repeats every 2 clks.
2. Run one full line -> video_on falls when pix_x goes 639->640; h_sinc goes low at pix_x=656 and returns high at pix_x=752 (192 clks low); pix_x wraps 799->0 while pix_y goes 0->1.
3. Run one full frame -> v_sinc low for pix_y 490..491 (3200 clks); the next frame_start arrives exactly 800*525*2 = 840000 clks after the previous one; video_on=0 for all of pix_y >= 480.
4. Drop en for 7 clks at pix_x=100 -> all outputs frozen, no pix_tick; after en returns, pix_x resumes at 101 at the next tick, keeping the same divider phase.
5. Assert rst_n=0 asynchronously at pix_y=300 -> outputs take their reset values immediately, without waiting for a clk edge; after release, frame_start arrives at (0,0) per scenario 1.
6. Set CLK_DIV=1 and SYNC_ACT=1 -> pix_tick constant 1, h_sinc high for 96 clks per line, frame period 420000 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// =============================================================================
// Package : vga_timing_pkg
// Brief   : 640x480@60 timing defaults, derived totals and a window compare.
// Revision: 1.0
// =============================================================================
package vga_timing_pkg;

    localparam int COORD_W = 11;

    localparam int VGA_CLK_DIV  = 2;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    // Counter is zero-extended to 32 bits so bounds are never truncated.
    function automatic logic in_window(input logic [COORD_W-1:0] cnt,
                                       input int lo, input int hi);
        int c;
        c = int'({{(32-COORD_W){1'b0}}, cnt});
        return (c >= lo) && (c <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_if.sv
`default_nettype none
// =============================================================================
// Interface : vga_sync_if
// Brief     : Run enable in, timing/sync/coordinate outputs of the sync stage.
// Revision  : 1.0
// =============================================================================
interface vga_sync_if;
    import vga_timing_pkg::*;

    logic               en;
    logic               pix_tick;
    logic               h_sinc;
    logic               v_sinc;
    logic               video_on;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               frame_start;

    modport master (
        input  en,
        output pix_tick, h_sinc, v_sinc, video_on, pix_x, pix_y, frame_start
    );

    modport slave (
        output en,
        input  pix_tick, h_sinc, v_sinc, video_on, pix_x, pix_y, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_gen_pix_tick_gen.sv
`default_nettype none
// =============================================================================
// Module  : pix_tick_gen
// Brief   : System-clock divider; tick strobes in the last clk of each period.
// Revision: 1.0
// =============================================================================
module pix_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic en,
    output logic      tick
);
    localparam int               DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             wrap;

    // tick is the advance strobe for the edge that closes this clk.
    always_comb begin
        wrap  = (div_q == DIV_MAX);
        div_d = div_q;
        if (en) begin
            div_d = wrap ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = en && wrap;
endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// =============================================================================
// Module  : vga_sync_gen
// Brief   : Pixel/line counters with registered, zero-skew sync/active decode.
// Revision: 1.0
// =============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_ACT = 1'b0
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    vga_sync_if.master  bus
);
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam logic [COORD_W-1:0] H_RST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_RST = COORD_W'(V_TOTAL - 1);

    logic adv;

    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic               pix_tick_q, pix_tick_d;
    logic               frame_start_q, frame_start_d;
    logic               video_on_q, video_on_d;
    logic               h_sinc_q, h_sinc_d;
    logic               v_sinc_q, v_sinc_d;
    logic               h_wrap, v_wrap;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .tick  (adv)
    );

    // Decodes use next-state counts so every output lands on the counter edge.
    always_comb begin
        h_wrap  = in_window(h_cnt_q, H_TOTAL - 1, H_TOTAL - 1);
        v_wrap  = in_window(v_cnt_q, V_TOTAL - 1, V_TOTAL - 1);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (adv) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            end
        end
        pix_tick_d    = adv;
        frame_start_d = adv && h_wrap && v_wrap;
        video_on_d    = in_window(h_cnt_d, 0, H_ACTIVE - 1) &&
                        in_window(v_cnt_d, 0, V_ACTIVE - 1);
        h_sinc_d      = in_window(h_cnt_d, H_SYNC_START, H_SYNC_END) ? SYNC_ACT : !SYNC_ACT;
        v_sinc_d      = in_window(v_cnt_d, V_SYNC_START, V_SYNC_END) ? SYNC_ACT : !SYNC_ACT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= H_RST;
            v_cnt_q       <= V_RST;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
            video_on_q    <= 1'b0;
            h_sinc_q      <= !SYNC_ACT;
            v_sinc_q      <= !SYNC_ACT;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
            video_on_q    <= video_on_d;
            h_sinc_q      <= h_sinc_d;
            v_sinc_q      <= v_sinc_d;
        end
    end

    assign bus.pix_x       = h_cnt_q;
    assign bus.pix_y       = v_cnt_q;
    assign bus.pix_tick    = pix_tick_q;
    assign bus.frame_start = frame_start_q;
    assign bus.video_on    = video_on_q;
    assign bus.h_sinc      = h_sinc_q;
    assign bus.v_sinc      = v_sinc_q;
endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// =============================================================================
// Module  : tb_vga_sync_gen
// Brief   : Scoreboarded bench: default 640x480 instance and a tiny-geometry
//           CLK_DIV=1 / active-high-sync instance.
// Revision: 1.0
// =============================================================================
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        von;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    typedef struct {
        int   ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
        logic act;
    } geo_t;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    logic mon_a = 1'b0;
    logic mon_b = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    geo_t geo_a, geo_b;

    vga_sync_if ia();
    vga_sync_if ib();

    vga_sync_gen dut_a (.clk(clk), .rst_n(rst_a_n), .bus(ia));

    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACT(1'b1)
    ) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(ib));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Closed-form expectation for the n-th tick after reset release (n=0 is (0,0)).
    function automatic exp_t model(input int n, input geo_t g);
        int   ht, vt, x, y;
        exp_t e;
        ht    = g.ha + g.hfp + g.hsw + g.hbp;
        vt    = g.va + g.vfp + g.vsw + g.vbp;
        x     = n % ht;
        y     = (n / ht) % vt;
        e.x   = 11'(x);
        e.y   = 11'(y);
        e.von = (x < g.ha) && (y < g.va);
        e.hs  = (x >= g.ha + g.hfp && x < g.ha + g.hfp + g.hsw) ? g.act : !g.act;
        e.vs  = (y >= g.va + g.vfp && y < g.va + g.vfp + g.vsw) ? g.act : !g.act;
        e.fs  = (x == 0) && (y == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_a && ia.pix_tick) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_a_extra: tick at x=%0d y=%0d with no expected entry", ia.pix_x, ia.pix_y);
            end else begin
                ea = qa.pop_front();
                chk("sb_a_x", 32'(ia.pix_x), 32'(ea.x));
                chk("sb_a_y", 32'(ia.pix_y), 32'(ea.y));
                chk("sb_a_flags", 32'({ia.video_on, ia.h_sinc, ia.v_sinc, ia.frame_start}),
                    32'({ea.von, ea.hs, ea.vs, ea.fs}));
            end
        end
    end

    always @(negedge clk) begin
        if (mon_b && ib.pix_tick) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_b_extra: tick at x=%0d y=%0d with no expected entry", ib.pix_x, ib.pix_y);
            end else begin
                eb = qb.pop_front();
                chk("sb_b_x", 32'(ib.pix_x), 32'(eb.x));
                chk("sb_b_y", 32'(ib.pix_y), 32'(eb.y));
                chk("sb_b_flags", 32'({ib.video_on, ib.h_sinc, ib.v_sinc, ib.frame_start}),
                    32'({eb.von, eb.hs, eb.vs, eb.fs}));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int hs_low, ticks, fs_cnt, last_fs, hs_hi, vs_hi, no_tick, bad_von;
        geo_a = '{VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP,
                  VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP, 1'b0};
        geo_b = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1};
        ia.en = 1'b1;
        ib.en = 1'b1;

        // Reset state of the default instance.
        repeat (2) @(negedge clk);
        chk("rst_x", 32'(ia.pix_x), 32'd799);
        chk("rst_y", 32'(ia.pix_y), 32'd524);
        chk("rst_flags", 32'({ia.pix_tick, ia.video_on, ia.h_sinc, ia.v_sinc, ia.frame_start}), 32'b00110);

        // First line: scoreboard every tick, measure sync width and tick rate.
        for (int n = 0; n < 802; n++) qa.push_back(model(n, geo_a));
        mon_a = 1'b1;
        @(negedge clk) rst_a_n = 1'b1;
        @(posedge clk) #1;
        chk("first_edge1_tick", 32'(ia.pix_tick), 32'd0);
        @(posedge clk) #1;
        chk("first_edge2_tick", 32'(ia.pix_tick), 32'd1);
        chk("first_edge2_fs", 32'(ia.frame_start), 32'd1);
        chk("first_edge2_xy", {5'd0, ia.pix_x, 5'd0, ia.pix_y}, 32'd0);
        chk("first_edge2_von", 32'(ia.video_on), 32'd1);
        hs_low = 0;
        ticks  = 0;
        for (int i = 0; i < 1600; i++) begin
            @(posedge clk) #1;
            if (ia.h_sinc == 1'b0) hs_low++;
            if (ia.pix_tick) ticks++;
        end
        chk("line_hsync_low_clks", 32'(hs_low), 32'd192);
        chk("line_tick_count", 32'(ticks), 32'd800);
        for (int k = 0; k < 20 && qa.size() != 0; k++) @(posedge clk) #1;
        mon_a = 1'b0;
        chk("sb_a_drain_line", 32'(qa.size()), 32'd0);

        // Freeze with en low at pix_x=100 on line 1.
        for (int k = 0; k < 400; k++) begin
            if (ia.pix_tick && ia.pix_x == 11'd100) break;
            @(posedge clk) #1;
        end
        chk("reach_x100", 32'(ia.pix_x), 32'd100);
        ia.en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk) #1;
            chk("frz_tick", 32'(ia.pix_tick), 32'd0);
            chk("frz_xy", {5'd0, ia.pix_x, 5'd0, ia.pix_y}, {16'd100, 16'd1});
            chk("frz_flags", 32'({ia.video_on, ia.h_sinc, ia.v_sinc, ia.frame_start}), 32'b1110);
        end
        ia.en = 1'b1;
        @(posedge clk) #1;
        chk("resume_edge1_tick", 32'(ia.pix_tick), 32'd0);
        chk("resume_edge1_x", 32'(ia.pix_x), 32'd100);
        @(posedge clk) #1;
        chk("resume_edge2_tick", 32'(ia.pix_tick), 32'd1);
        chk("resume_edge2_x", 32'(ia.pix_x), 32'd101);

        // Asynchronous reset between edges, then restart from (0,0).
        #2 rst_a_n = 1'b0;
        #1;
        chk("arst_x", 32'(ia.pix_x), 32'd799);
        chk("arst_y", 32'(ia.pix_y), 32'd524);
        chk("arst_flags", 32'({ia.pix_tick, ia.video_on, ia.h_sinc, ia.v_sinc, ia.frame_start}), 32'b00110);
        for (int n = 0; n < 3; n++) qa.push_back(model(n, geo_a));
        mon_a = 1'b1;
        @(negedge clk) rst_a_n = 1'b1;
        @(posedge clk) #1;
        chk("rerun_edge1_tick", 32'(ia.pix_tick), 32'd0);
        @(posedge clk) #1;
        chk("rerun_edge2_fs", 32'({ia.pix_tick, ia.frame_start}), 32'b11);
        chk("rerun_edge2_xy", {5'd0, ia.pix_x, 5'd0, ia.pix_y}, 32'd0);
        for (int k = 0; k < 20 && qa.size() != 0; k++) @(posedge clk) #1;
        mon_a = 1'b0;
        chk("sb_a_drain_rst", 32'(qa.size()), 32'd0);

        // Tiny geometry, CLK_DIV=1, active-high sync: two whole frames.
        for (int n = 0; n < 241; n++) qb.push_back(model(n, geo_b));
        mon_b = 1'b1;
        @(negedge clk) rst_b_n = 1'b1;
        @(posedge clk) #1;
        chk("b_edge1_tick_fs", 32'({ib.pix_tick, ib.frame_start}), 32'b11);
        chk("b_edge1_xy", {5'd0, ib.pix_x, 5'd0, ib.pix_y}, 32'd0);
        fs_cnt  = 0;
        last_fs = 0;
        hs_hi   = 0;
        vs_hi   = 0;
        no_tick = 0;
        bad_von = 0;
        for (int i = 1; i <= 240; i++) begin
            @(posedge clk) #1;
            if (!ib.pix_tick) no_tick++;
            if (ib.h_sinc) hs_hi++;
            if (ib.v_sinc) vs_hi++;
            if (ib.video_on && ib.pix_y >= 11'd4) bad_von++;
            if (ib.frame_start) begin
                fs_cnt++;
                chk("b_frame_period", 32'(i - last_fs), 32'd120);
                last_fs = i;
            end
        end
        chk("b_tick_gaps", 32'(no_tick), 32'd0);
        chk("b_hsync_high_clks", 32'(hs_hi), 32'd48);
        chk("b_vsync_high_clks", 32'(vs_hi), 32'd60);
        chk("b_frame_count", 32'(fs_cnt), 32'd2);
        chk("b_von_in_blank", 32'(bad_von), 32'd0);
        for (int k = 0; k < 10 && qb.size() != 0; k++) @(posedge clk) #1;
        mon_b = 1'b0;
        chk("sb_b_drain", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
